spi_regbank: RTL

SPI_REGBANK -- requirements
Module: spi_regbank

---
 rtl/spi_regbank.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_regbank.sv
// SPI-mapped register bank: motor PWM/control registers, encoder snapshots, frame counters and a watchdog.
// Writes land 4 Clk edges after raw CS is first sampled high; read data re-registered every cycle; no backpressure.
module spi_regbank #(
  parameter logic [31:0] ID_VALUE   = 32'h4D42_0001,
  parameter int unsigned WDT_CYCLES = 50_000_000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        SPI_CS,
  input  logic        SPI_CLK,
  input  logic [7:0]  DataAddr,
  input  logic [31:0] DataToFPGA,
  output logic [31:0] DataToRPi,
  input  logic [31:0] EncL,
  input  logic [31:0] EncR,
  input  logic [31:0] StatusIn,
  output logic [15:0] PwmL,
  output logic [15:0] PwmR,
  output logic [31:0] Ctrl,
  output logic        WdtExpired
);

  localparam logic [31:0] WDT_LOAD = 32'(WDT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

  state_t      state;
  logic        cs_s1, cs_s2, cs_h;
  logic        sck_s1, sck_s2, sck_h;
  logic [1:0]  warm;
  logic        armed;
  logic [5:0]  edge_cnt;
  logic [31:0] snap_l, snap_r, scratch, wdt_cnt;
  logic [15:0] frame_cnt, abort_cnt;
  logic        cs_fall, cs_rise, sck_rise;

  assign cs_fall  = cs_h & ~cs_s2;
  assign cs_rise  = ~cs_h & cs_s2;
  assign sck_rise = ~sck_h & sck_s2;

  // Framing is armed only after a genuinely sampled CS-high, so the tail of a
  // frame cut short by reset cannot start a new frame or count as an abort.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
      cs_h   <= 1'b1;
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_h  <= 1'b0;
      warm   <= 2'd0;
      armed  <= 1'b0;
    end else begin
      cs_s1  <= SPI_CS;
      cs_s2  <= cs_s1;
      cs_h   <= cs_s2;
      sck_s1 <= SPI_CLK;
      sck_s2 <= sck_s1;
      sck_h  <= sck_s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
      if (warm[1] && cs_s2) armed <= 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      edge_cnt  <= 6'd0;
      snap_l    <= 32'h0;
      snap_r    <= 32'h0;
      frame_cnt <= 16'h0;
      abort_cnt <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            state    <= ACTIVE;
            snap_l   <= EncL;
            snap_r   <= EncR;
            edge_cnt <= 6'd0;
          end
        end
        ACTIVE: begin
          if (sck_rise && edge_cnt != 6'd63) edge_cnt <= edge_cnt + 6'd1;
          if (cs_rise) begin
            if (edge_cnt == 6'd40) begin
              state <= COMMIT;
            end else begin
              state     <= IDLE;
              abort_cnt <= abort_cnt + 16'd1;
            end
          end
        end
        COMMIT: begin
          state     <= IDLE;
          frame_cnt <= frame_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A commit outranks watchdog expiry in the same cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PwmL       <= 16'h0;
      PwmR       <= 16'h0;
      Ctrl       <= 32'h0;
      scratch    <= 32'h0;
      wdt_cnt    <= WDT_LOAD;
      WdtExpired <= 1'b0;
    end else if (state == COMMIT) begin
      wdt_cnt    <= WDT_LOAD;
      WdtExpired <= 1'b0;
      if (DataAddr[7]) begin
        case (DataAddr[6:0])
          7'h10:   PwmL    <= DataToFPGA[15:0];
          7'h11:   PwmR    <= DataToFPGA[15:0];
          7'h12:   Ctrl    <= DataToFPGA;
          7'h13:   scratch <= DataToFPGA;
          default: ;
        endcase
      end
    end else if (wdt_cnt == 32'h0) begin
      WdtExpired <= 1'b1;
      PwmL       <= 16'h0;
      PwmR       <= 16'h0;
    end else begin
      wdt_cnt <= wdt_cnt - 32'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DataToRPi <= 32'h0;
    end else begin
      case (DataAddr[6:0])
        7'h00:   DataToRPi <= ID_VALUE;
        7'h01:   DataToRPi <= snap_l;
        7'h02:   DataToRPi <= snap_r;
        7'h03:   DataToRPi <= StatusIn;
        7'h10:   DataToRPi <= {16'h0, PwmL};
        7'h11:   DataToRPi <= {16'h0, PwmR};
        7'h12:   DataToRPi <= Ctrl;
        7'h13:   DataToRPi <= scratch;
        7'h7E:   DataToRPi <= {abort_cnt, frame_cnt};
        7'h7F:   DataToRPi <= {31'h0, WdtExpired};
        default: DataToRPi <= 32'h0;
      endcase
    end
  end

endmodule
